// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the mips32 shared memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIBusy = 2'd1,
        StDBusy = 2'd2
    } arb_state_e;

    localparam logic [3:0] BeFull = 4'hF;

    localparam int unsigned StarveMaxDefault = 4;

endpackage

// File: rtl/arb_starve_guard.sv
// Counts data grants issued while fetch is waiting and forces the next idle grant to fetch
// once the count reaches STARVE_MAX.
module arb_starve_guard
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = StarveMaxDefault
) (
    input  logic clk,
    input  logic rst_n,
    input  logic idle,
    input  logic ireq,
    input  logic dgnt,
    input  logic ignt,
    output logic force_fetch
);

    localparam logic [3:0] StarveMaxC = 4'(STARVE_MAX);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        // An idle cycle with no fetch pending means fetch is not being starved.
        if (ignt || (idle && !ireq)) begin
            cnt_d = 4'd0;
        end else if (dgnt && ireq && (cnt_q != 4'hF)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_fetch = ireq && (cnt_q == StarveMaxC);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the MEM stage, data first.
// Define MEM_ARB_STARVE_GUARD_EN to bound how many data grants may pass a waiting fetch.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = StarveMaxDefault
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              ireq,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              ignt,
    output logic              ivalid,
    output logic [DATA_W-1:0] irdata,

    input  logic              dreq,
    input  logic              dwe,
    input  logic [3:0]        dbe,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dwdata,
    output logic              dgnt,
    output logic              dvalid,
    output logic [DATA_W-1:0] drdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              stall_if,
    output logic              stall_mem
);

    arb_state_e state_q, state_d;

    logic              idle;
    logic              force_fetch;

    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] irdata_q, irdata_d;
    logic [DATA_W-1:0] drdata_q, drdata_d;
    logic              ivalid_q, ivalid_d;
    logic              dvalid_q, dvalid_d;

    assign idle = (state_q == StIdle);

`ifdef MEM_ARB_STARVE_GUARD_EN
    arb_starve_guard #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_guard (
        .clk         (clk),
        .rst_n       (rst_n),
        .idle        (idle),
        .ireq        (ireq),
        .dgnt        (dgnt),
        .ignt        (ignt),
        .force_fetch (force_fetch)
    );
`else
    assign force_fetch = 1'b0;

    logic unused_starve_max;
    assign unused_starve_max = ^STARVE_MAX;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (dgnt) begin
                    state_d = StDBusy;
                end else if (ignt) begin
                    state_d = StIBusy;
                end
            end
            StIBusy, StDBusy: begin
                if (mem_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Grants are combinational so a new access can start in the valid-pulse cycle.
    always_comb begin
        ignt    = 1'b0;
        dgnt    = 1'b0;
        mem_req = !idle;
        if (idle) begin
            if (ireq && (force_fetch || !dreq)) begin
                ignt = 1'b1;
            end else if (dreq) begin
                dgnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        irdata_d    = irdata_q;
        drdata_d    = drdata_q;
        ivalid_d    = 1'b0;
        dvalid_d    = 1'b0;

        if (dgnt) begin
            mem_we_d    = dwe;
            mem_be_d    = dbe;
            mem_addr_d  = daddr;
            mem_wdata_d = dwdata;
        end else if (ignt) begin
            mem_we_d   = 1'b0;
            mem_be_d   = BeFull;
            mem_addr_d = iaddr;
        end

        if (mem_ack && (state_q == StIBusy)) begin
            irdata_d = mem_rdata;
            ivalid_d = 1'b1;
        end
        if (mem_ack && (state_q == StDBusy)) begin
            drdata_d = mem_we_q ? '0 : mem_rdata;
            dvalid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            irdata_q    <= '0;
            drdata_q    <= '0;
            ivalid_q    <= 1'b0;
            dvalid_q    <= 1'b0;
        end else begin
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            irdata_q    <= irdata_d;
            drdata_q    <= drdata_d;
            ivalid_q    <= ivalid_d;
            dvalid_q    <= dvalid_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign irdata    = irdata_q;
    assign drdata    = drdata_q;
    assign ivalid    = ivalid_q;
    assign dvalid    = dvalid_q;

    assign stall_if  = ireq && !ivalid_q;
    assign stall_mem = dreq && !dvalid_q;

    a_grant_mutex: assert property (@(posedge clk) disable iff (!rst_n) !(ignt && dgnt));

    a_fields_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (mem_req && !mem_ack) |=> $stable({mem_we, mem_be, mem_addr, mem_wdata}));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter plus starvation and mid-access reset
// sequences; expected starvation pattern follows MEM_ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        ack;
        logic [31:0] rdata;
    } in_t;

    typedef struct packed {
        logic        ignt;
        logic        dgnt;
        logic        mreq;
        logic        mwe;
        logic [3:0]  mbe;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic        ivalid;
        logic [31:0] irdata;
        logic        dvalid;
        logic [31:0] drdata;
        logic        stall_if;
        logic        stall_mem;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
        logic care_wd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ireq, dreq, dwe, mem_ack;
    logic [31:0] iaddr, daddr, dwdata, mem_rdata;
    logic [3:0]  dbe;
    logic        ignt, ivalid, dgnt, dvalid, mem_req, mem_we, stall_if, stall_mem;
    logic [31:0] irdata, drdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int n_checks = 0;
    int n_pass   = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ireq      (ireq),
        .iaddr     (iaddr),
        .ignt      (ignt),
        .ivalid    (ivalid),
        .irdata    (irdata),
        .dreq      (dreq),
        .dwe       (dwe),
        .dbe       (dbe),
        .daddr     (daddr),
        .dwdata    (dwdata),
        .dgnt      (dgnt),
        .dvalid    (dvalid),
        .drdata    (drdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    task automatic row(input in_t i, input exp_t e, input logic care_wd);
        vec_t v;
        v.i       = i;
        v.e       = e;
        v.care_wd = care_wd;
        tbl.push_back(v);
    endtask

    task automatic drive(input in_t i);
        ireq      = i.ireq;
        iaddr     = i.iaddr;
        dreq      = i.dreq;
        dwe       = i.dwe;
        dbe       = i.dbe;
        daddr     = i.daddr;
        dwdata    = i.dwdata;
        mem_ack   = i.ack;
        mem_rdata = i.rdata;
    endtask

    function automatic exp_t sample();
        return exp_t'{ignt, dgnt, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
                      ivalid, irdata, dvalid, drdata, stall_if, stall_mem};
    endfunction

    task automatic chk_vec(input string name, input exp_t act, input exp_t exp,
                           input logic care_wd);
        exp_t a, e;
        a = act;
        e = exp;
        // Write data is unspecified after a fetch grant, so those rows ignore it.
        if (!care_wd) begin
            a.mwdata = '0;
            e.mwdata = '0;
        end
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h required %h", name, a, e);
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] is_fetch;
        logic       both;
        int         ng;
        int         cyc;
        logic       exp_f;

        // single fetch, zero wait
        row(in_t'{1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0},
            exp_t'{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                   1'b1, 1'b0}, 1'b1);
        row(in_t'{1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h2408_0005},
            exp_t'{1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                   1'b1, 1'b0}, 1'b0);
        row(in_t'{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0},
            exp_t'{1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1, 32'h2408_0005, 1'b0,
                   32'h0, 1'b0, 1'b0}, 1'b0);
        // ack while idle is ignored
        row(in_t'{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0001_2345},
            exp_t'{1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 32'h2408_0005, 1'b0,
                   32'h0, 1'b0, 1'b0}, 1'b0);
        // data read, zero wait
        row(in_t'{1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h200, 32'h55, 1'b0, 32'h0},
            exp_t'{1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 32'h2408_0005, 1'b0,
                   32'h0, 1'b0, 1'b1}, 1'b0);
        row(in_t'{1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h200, 32'h55, 1'b1, 32'h1122_3344},
            exp_t'{1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h200, 32'h55, 1'b0, 32'h2408_0005, 1'b0,
                   32'h0, 1'b0, 1'b1}, 1'b1);
        row(in_t'{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0},
            exp_t'{1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 32'h200, 32'h55, 1'b0, 32'h2408_0005, 1'b1,
                   32'h1122_3344, 1'b0, 1'b0}, 1'b1);
        // data write, three wait cycles; requester fields change after the grant
        row(in_t'{1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF, 1'b0, 32'h0},
            exp_t'{1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 32'h200, 32'h55, 1'b0, 32'h2408_0005, 1'b0,
                   32'h1122_3344, 1'b0, 1'b1}, 1'b1);
        for (int k = 0; k < 4; k++) begin
            row(in_t'{1'b0, 32'h0, 1'b1, 1'b1, 4'hC, 32'hFFFF_FFFC, 32'h0, (k == 3),
                      32'hCAFE_F00D},
                exp_t'{1'b0, 1'b0, 1'b1, 1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF, 1'b0,
                       32'h2408_0005, 1'b0, 32'h1122_3344, 1'b0, 1'b1}, 1'b1);
        end
        row(in_t'{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0},
            exp_t'{1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF, 1'b0, 32'h2408_0005,
                   1'b1, 32'h0, 1'b0, 1'b0}, 1'b1);
        // contention: data first, fetch granted in the dvalid cycle
        row(in_t'{1'b1, 32'h40, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 1'b0, 32'h0},
            exp_t'{1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF, 1'b0, 32'h2408_0005,
                   1'b0, 32'h0, 1'b1, 1'b1}, 1'b1);
        row(in_t'{1'b1, 32'h40, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 1'b1, 32'hAAAA_0001},
            exp_t'{1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 1'b0, 32'h2408_0005, 1'b0,
                   32'h0, 1'b1, 1'b1}, 1'b1);
        row(in_t'{1'b1, 32'h40, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0},
            exp_t'{1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 32'h300, 32'h0, 1'b0, 32'h2408_0005, 1'b1,
                   32'hAAAA_0001, 1'b1, 1'b0}, 1'b1);
        row(in_t'{1'b1, 32'h40, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h8C09_0000},
            exp_t'{1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0, 1'b0, 32'h2408_0005, 1'b0,
                   32'hAAAA_0001, 1'b1, 1'b0}, 1'b0);
        row(in_t'{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0},
            exp_t'{1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 32'h40, 32'h0, 1'b1, 32'h8C09_0000, 1'b0,
                   32'hAAAA_0001, 1'b0, 1'b0}, 1'b0);
        row(in_t'{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0},
            exp_t'{1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 32'h40, 32'h0, 1'b0, 32'h8C09_0000, 1'b0,
                   32'hAAAA_0001, 1'b0, 1'b0}, 1'b0);

        rst_n = 1'b0;
        drive('0);
        #12;
        chk_vec("reset_values", sample(), '0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[k]) begin
            drive(tbl[k].i);
            @(negedge clk);
            chk_vec($sformatf("vec%0d", k), sample(), tbl[k].e, tbl[k].care_wd);
            @(posedge clk);
            #1;
        end

        // both requesters held high with zero-wait memory
        drive(in_t'{1'b1, 32'h600, 1'b1, 1'b0, 4'hF, 32'h500, 32'h0, 1'b1, 32'h0});
        is_fetch = '0;
        both     = 1'b0;
        ng       = 0;
        cyc      = 0;
        while (ng < 10 && cyc < 40) begin
            @(negedge clk);
            if (ignt || dgnt) begin
                is_fetch[ng] = ignt;
                if (ignt && dgnt) both = 1'b1;
                ng++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk64("starve_grant_count", 64'(ng), 64'd10);
        chk64("starve_double_grant", 64'(both), 64'd0);
        for (int k = 0; k < 10; k++) begin
            if (k < ng) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
                exp_f = ((k % 5) == 4);
`else
                exp_f = 1'b0;
`endif
                chk64($sformatf("starve_grant%0d_is_fetch", k), 64'(is_fetch[k]), 64'(exp_f));
            end
        end
        drive(in_t'{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0});
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(posedge clk);
        #1;

        // reset during a data write wait state
        drive(in_t'{1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h700, 32'h1234_5678, 1'b0, 32'h0});
        @(negedge clk);
        chk64("rst_seq_dgnt", 64'(dgnt), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk64("rst_seq_busy", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, 32'h700});
        #2;
        rst_n = 1'b0;
        drive('0);
        #1;
        chk_vec("rst_mid_outputs", sample(), '0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        drive(in_t'{1'b1, 32'h800, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0F0F_0F0F});
        #1;
        chk64("rst_release_ignt", {62'd0, ignt, dgnt}, {62'd0, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        chk64("rst_release_busy", {30'd0, dvalid, mem_req, mem_addr},
              {30'd0, 1'b0, 1'b1, 32'h800});
        @(posedge clk);
        #1;
        chk64("rst_release_fetch_done", {30'd0, ivalid, dvalid, irdata},
              {30'd0, 1'b1, 1'b0, 32'h0F0F_0F0F});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences the single shared memory port between the instruction-fetch stage and the data-memory (MEM) stage of the mips32 pipeline. The block accepts one request at a time, holds it on the memory port until acknowledged, and returns read data with a one-cycle valid pulse. It also generates the stall signals that freeze the fetch PC and the MEM stage while their access is outstanding. Data accesses have priority over fetch.

## Interface
- ADDR_W, 32, address width of all address ports
- DATA_W, 32, data width of all data ports
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits (only with guard enabled, range 1..15)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ireq  in  1  fetch request (driven from fetch-stage instruction-valid)
- iaddr  in  ADDR_W  fetch address
- ignt  out  1  fetch request accepted this cycle
- ivalid  out  1  one-cycle pulse, irdata valid
- irdata  out  DATA_W  fetched instruction
- dreq  in  1  data request
- dwe  in  1  1 = write, 0 = read
- dbe  in  4  byte enables (writes)
- daddr  in  ADDR_W  data address
- dwdata  in  DATA_W  write data
- dgnt  out  1  data request accepted this cycle
- dvalid  out  1  one-cycle pulse, access complete (reads and writes)
- drdata  out  DATA_W  read data (0 for writes)
- mem_req  out  1  memory port request, held until mem_ack
- mem_we, mem_be, mem_addr, mem_wdata  out  1/4/ADDR_W/DATA_W  latched request fields
- mem_ack  in  1  memory completes the access this cycle
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- stall_if  out  1  hold fetch PC
- stall_mem  out  1  hold MEM stage

## Operation
- FSM states: IDLE, I_BUSY, D_BUSY.
- IDLE: if dreq, assert dgnt (combinational), latch dwe/dbe/daddr/dwdata, go to D_BUSY. Otherwise, if ireq, assert ignt, latch iaddr (mem_we=0, mem_be=4'hF), go to I_BUSY. At most one grant per cycle.
- I_BUSY/D_BUSY: mem_req=1 with the latched fields held stable. On mem_ack: register mem_rdata into irdata or drdata (drdata=0 for writes), pulse the matching valid on the next cycle, return to IDLE.
- mem_ack in IDLE is ignored.
- Requesters hold req and fields stable until granted; after the grant they may change freely.
- stall_if = ireq & ~ivalid. stall_mem = dreq & ~dvalid.
- A request deasserted before its grant is dropped silently. Once granted, an access always completes.
- irdata/drdata keep their last value between valid pulses.

## Timing
- Reset values: state IDLE; mem_req, mem_we, ivalid, dvalid = 0; mem_be = 0; mem_addr, mem_wdata, irdata, drdata = 0; guard counter = 0.
- Grant in cycle N. mem_req is high from N+1. With mem_ack in N+1 (zero wait), valid pulses in N+2.
- Latency is 2 + W cycles, where W is the number of memory wait cycles.
- The FSM is in IDLE during the valid cycle, so a new grant can be issued in that same cycle. Back-to-back throughput is one access per 2 cycles at zero wait.
- If dreq and ireq are both high in IDLE, data wins (subject to Configuration).
- If rst_n is asserted mid-access, mem_req drops immediately and the access is abandoned. No valid pulse follows.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined: a 4-bit counter increments on each dgnt issued while ireq is high. It clears on ignt, or when a cycle passes in IDLE with ireq low. When the count equals STARVE_MAX and ireq is high, the next IDLE grant goes to fetch even if dreq is high.
- MEM_ARB_STARVE_GUARD_EN undefined: strict data priority. The counter and its logic are absent.

## Structure
- Shared package `mem_arb_pkg`: FSM state encodings (IDLE=2'd0, I_BUSY=2'd1, D_BUSY=2'd2), full byte-enable constant, default STARVE_MAX.
- Optional sub-module `arb_starve_guard`: the counter plus the force-fetch output. It is instantiated only under MEM_ARB_STARVE_GUARD_EN. The FSM and datapath latches stay in the top module.

## Test plan
- Single fetch: ireq=1, iaddr=0x0000_0010, mem_ack in the first mem_req cycle with mem_rdata=0x2408_0005. Expect: ignt at N; mem_addr=0x10, mem_we=0 at N+1; ivalid=1 with irdata=0x2408_0005 at N+2; stall_if high at N and N+1.
- Data write with 3 wait cycles: daddr=0x100, dwdata=0xDEAD_BEEF, dbe=4'b0011. Expect: mem_req held for 4 cycles with stable fields; dvalid at N+5 with drdata=0.
- Contention: dreq and ireq high together in IDLE. Expect: dgnt first, ignt in the cycle dvalid pulses, fetch completes after.
- Starvation guard (macro on, STARVE_MAX=4): dreq and ireq held high continuously. Expect: 4 data grants, then 1 fetch grant, repeating. With the macro off: no fetch grant while dreq stays high.
- Reset mid-access: rst_n low during D_BUSY wait. Expect: mem_req=0 immediately, all outputs at reset values, no dvalid after release, IDLE grant possible at the first cycle after release.
